// File: rtl/video_timing_pkg.sv
// Shared timing descriptions and size helpers for the raster timing generator.
// Presets let integrators pick a standard mode without re-deriving porch values.
package video_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } video_timing_t;

    localparam video_timing_t TIMING_320x240_NTSC = '{
        h_active: 320, h_fp: 8, h_sync: 32, h_bp: 40,
        v_active: 240, v_fp: 3, v_sync: 4, v_bp: 15
    };

    localparam video_timing_t TIMING_640x480_VGA = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33
    };

    function automatic int h_total(video_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int v_total(video_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_timing_gen_ce_div.sv
// Pixel-rate divider: counts CE_DIV (or CE_DIV/2 when doubled) clocks per pixel.
// adv_o is the combinational "advance on this edge" strobe; ce_pix_o is its registered copy.
module video_ce_div #(
    parameter int CE_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dbl_i,
    output logic adv_o,
    output logic ce_pix_o
);

    localparam int DW = (CE_DIV <= 2) ? 1 : $clog2(CE_DIV);

    logic [DW-1:0] cdiv_q, cdiv_d;
    logic          ce_q;
    int            div_m1;

    always_comb begin
        div_m1 = dbl_i ? (CE_DIV / 2) - 1 : CE_DIV - 1;
        // ">=" keeps the counter safe if the length ever shrinks mid-count.
        adv_o  = (int'(cdiv_q) >= div_m1);
        cdiv_d = adv_o ? '0 : cdiv_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cdiv_q <= '0;
            ce_q   <= 1'b0;
        end else begin
            cdiv_q <= cdiv_d;
            ce_q   <= adv_o;
        end
    end

    assign ce_pix_o = ce_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, sync/blank and position counters, with an
// optional scandouble mode (half divider, each source line emitted twice).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 15,
    parameter int CE_DIV   = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    localparam video_timing_t CFG = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    },
    localparam int H_TOTAL = h_total(CFG),
    localparam int V_TOTAL = v_total(CFG),
    localparam int HW      = cnt_width(H_TOTAL),
    localparam int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          scandouble,
    output logic          ce_pix,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          line_rep,
    output logic          line_start,
    output logic          frame_start,
    output logic          mode_dbl
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam int            HS_START = H_ACTIVE + H_FP;
    localparam int            HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int            VS_START = V_ACTIVE + V_FP;
    localparam int            VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic          adv;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          rep_q, rep_d;
    logic          mode_q, mode_d;
    logic          hblank_q, vblank_q, hsync_q, vsync_q;
    logic          line_start_q, frame_start_q;
    logic          h_wrap, frame_wrap, rep_out_d;

    video_ce_div #(
        .CE_DIV (CE_DIV)
    ) u_ce_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .dbl_i    (mode_q),
        .adv_o    (adv),
        .ce_pix_o (ce_pix)
    );

    // In normal mode rep_q sits at 1 so "vcount steps when rep leaves 1" holds in both modes.
    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        rep_d      = rep_q;
        mode_d     = mode_q;
        h_wrap     = (h_q == H_LAST);
        frame_wrap = h_wrap && rep_q && (v_q == V_LAST);
        if (adv) begin
            if (frame_wrap) begin
                mode_d = scandouble;
            end
            if (h_wrap) begin
                h_d   = '0;
                rep_d = mode_d ? ~rep_q : 1'b1;
                if (rep_q) begin
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        rep_out_d = mode_d & rep_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            rep_q         <= 1'b1;
            mode_q        <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            rep_q         <= rep_d;
            mode_q        <= mode_d;
            hblank_q      <= (int'(h_d) >= H_ACTIVE);
            vblank_q      <= (int'(v_d) >= V_ACTIVE);
            hsync_q       <= (int'(h_d) >= HS_START && int'(h_d) < HS_END) ? HS_POL : ~HS_POL;
            vsync_q       <= (int'(v_d) >= VS_START && int'(v_d) < VS_END) ? VS_POL : ~VS_POL;
            line_start_q  <= adv && (h_d == '0);
            frame_start_q <= adv && (h_d == '0) && (v_d == '0) && !rep_out_d;
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign line_rep    = mode_q & rep_q;
    assign mode_dbl    = mode_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster (16x10 totals, CE_DIV 4)
// so whole frames in both modes fit in a short run.
module tb_video_timing_gen;

    localparam int HA = 8,  HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int CED = 4;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FRAME_CLKS = CED * HT * VT; // 640

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scandouble = 1'b0;
    logic       ce_pix, HBlank, VBlank, HSync, VSync;
    logic [3:0] hcount;
    logic [3:0] vcount;
    logic       line_rep, line_start, frame_start, mode_dbl;

    int errors = 0;
    int checks = 0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CE_DIV(CED), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .scandouble  (scandouble),
        .ce_pix      (ce_pix),
        .HBlank      (HBlank),
        .VBlank      (VBlank),
        .HSync       (HSync),
        .VSync       (VSync),
        .hcount      (hcount),
        .vcount      (vcount),
        .line_rep    (line_rep),
        .line_start  (line_start),
        .frame_start (frame_start),
        .mode_dbl    (mode_dbl)
    );

    always #5 clk = ~clk;

    // Advance to the next ce_pix pulse, sampling 1 time unit after each rising edge.
    task automatic next_pulse(output int gap);
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!ce_pix && gap < 64);
        if (!ce_pix) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout: no ce_pix after %0d clocks, required one within %0d", gap, 2 * CED);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({ce_pix, hcount, vcount} !== {1'b0, 4'd15, 4'd9}) begin
            errors++;
            $display("FAIL %s_pos: ce/h/v=%b/%0d/%0d required 0/15/9", tag, ce_pix, hcount, vcount);
        end
        checks++;
        if ({HBlank, VBlank, HSync, VSync} !== 4'b1111) begin
            errors++;
            $display("FAIL %s_syncblank: HB/VB/HS/VS=%b%b%b%b required 1111", tag, HBlank, VBlank, HSync, VSync);
        end
        checks++;
        if ({line_start, frame_start, mode_dbl} !== 3'b000) begin
            errors++;
            $display("FAIL %s_flags: ls/fs/mode=%b%b%b required 000", tag, line_start, frame_start, mode_dbl);
        end
    endtask

    task automatic release_and_first_pulse(input string tag);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= CED; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ce_pix !== (k == CED)) begin
                errors++;
                $display("FAIL %s_ce_clk%0d: ce_pix=%b required %b", tag, k, ce_pix, (k == CED));
            end
        end
        checks++;
        if ({hcount, vcount, line_rep, line_start, frame_start, HBlank} !== {4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s_first: h/v/rep/ls/fs/HB=%0d/%0d/%b/%b/%b/%b required 0/0/0/1/1/0",
                     tag, hcount, vcount, line_rep, line_start, frame_start, HBlank);
        end
        $display("%s: first pulse h=%0d v=%0d fs=%b", tag, hcount, vcount, frame_start);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        scandouble = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        $display("test_reset: h=%0d v=%0d", hcount, vcount);
    endtask

    task automatic test_first_pulse();
        int gap;
        release_and_first_pulse("first_pulse");
        next_pulse(gap);
        checks++;
        if (gap !== CED || hcount !== 4'd1) begin
            errors++;
            $display("FAIL second_pulse: gap=%0d h=%0d required %0d/1", gap, hcount, CED);
        end
    endtask

    // Currently at pulse (h=1, v=0); walk to the start of line 1 checking each pixel.
    task automatic test_line_sweep();
        int gap;
        int line_clks = CED;
        int sync_cnt = 0;
        for (int p = 2; p <= HT; p++) begin
            int eh;
            eh = p % HT;
            next_pulse(gap);
            line_clks += gap;
            checks++;
            if (gap !== CED || hcount !== eh[3:0]) begin
                errors++;
                $display("FAIL line_pos: gap=%0d h=%0d required %0d/%0d", gap, hcount, CED, eh);
            end
            checks++;
            if (HBlank !== (eh >= HA) || HSync !== !(eh >= 10 && eh < 13) || line_start !== (eh == 0)) begin
                errors++;
                $display("FAIL line_flags: h=%0d HB/HS/ls=%b%b%b required %b%b%b",
                         eh, HBlank, HSync, line_start, (eh >= HA), !(eh >= 10 && eh < 13), (eh == 0));
            end
            if (!HSync) sync_cnt++;
        end
        checks++;
        if (vcount !== 4'd1 || frame_start !== 1'b0 || line_clks !== CED * HT || sync_cnt !== HS) begin
            errors++;
            $display("FAIL line_wrap: v=%0d fs=%b clks=%0d hsync_pix=%0d required 1/0/%0d/%0d",
                     vcount, frame_start, line_clks, sync_cnt, CED * HT, HS);
        end
        $display("test_line_sweep: line period %0d clocks, hsync %0d pixels", line_clks, sync_cnt);
    endtask

    task automatic test_frame_sweep();
        int gap;
        int total = 0;
        int ev = 0;
        int n = 0;
        while (!frame_start && n < 400) begin
            next_pulse(gap);
            n++;
        end
        checks++;
        if (VBlank !== 1'b0 || VSync !== 1'b1) begin
            errors++;
            $display("FAIL frame_top: VB/VS=%b%b required 01", VBlank, VSync);
        end
        n = 0;
        do begin
            next_pulse(gap);
            total += gap;
            n++;
            if (line_start && !frame_start) begin
                ev++;
                checks++;
                if (vcount !== ev[3:0] || VBlank !== (ev >= VA) || VSync !== !(ev >= 7 && ev < 9)) begin
                    errors++;
                    $display("FAIL frame_line: v=%0d VB/VS=%b%b required %0d %b%b",
                             vcount, VBlank, VSync, ev, (ev >= VA), !(ev >= 7 && ev < 9));
                end
            end
        end while (!frame_start && n < 400);
        checks++;
        if (total !== FRAME_CLKS || ev !== VT - 1) begin
            errors++;
            $display("FAIL frame_period: clks=%0d lines=%0d required %0d/%0d", total, ev + 1, FRAME_CLKS, VT);
        end
        $display("test_frame_sweep: frame period %0d clocks", total);
    endtask

    // Starts on a normal-mode frame_start pulse.
    task automatic test_mode_switch();
        int gap;
        int n = 0;
        int total = 0;
        int eline = 0;
        int vs_lines, vb_lines;
        repeat (20) next_pulse(gap);
        scandouble = 1'b1;
        do begin
            checks++;
            if (mode_dbl !== 1'b0) begin
                errors++;
                $display("FAIL mode_early: mode_dbl=%b at h=%0d v=%0d required 0", mode_dbl, hcount, vcount);
            end
            next_pulse(gap);
            n++;
        end while (!frame_start && n < 400);
        checks++;
        if (mode_dbl !== 1'b1 || line_rep !== 1'b0 || vcount !== 4'd0) begin
            errors++;
            $display("FAIL mode_latch: mode/rep/v=%b/%b/%0d required 1/0/0", mode_dbl, line_rep, vcount);
        end
        vs_lines = (VSync == 1'b0) ? 1 : 0;
        vb_lines = (VBlank == 1'b1) ? 1 : 0;
        n = 0;
        do begin
            next_pulse(gap);
            total += gap;
            n++;
            checks++;
            if (gap !== CED / 2) begin
                errors++;
                $display("FAIL dbl_gap: gap=%0d at h=%0d required %0d", gap, hcount, CED / 2);
            end
            if (line_start && !frame_start) begin
                eline++;
                checks++;
                if (vcount !== 4'(eline / 2) || line_rep !== 1'(eline % 2)) begin
                    errors++;
                    $display("FAIL dbl_line: v/rep=%0d/%b required %0d/%0d", vcount, line_rep, eline / 2, eline % 2);
                end
                if (!VSync) vs_lines++;
                if (VBlank) vb_lines++;
            end
        end while (!frame_start && n < 800);
        checks++;
        if (total !== FRAME_CLKS || eline !== 2 * VT - 1) begin
            errors++;
            $display("FAIL dbl_period: clks=%0d lines=%0d required %0d/%0d", total, eline + 1, FRAME_CLKS, 2 * VT);
        end
        checks++;
        if (vs_lines !== 2 * VS || vb_lines !== 2 * (VT - VA)) begin
            errors++;
            $display("FAIL dbl_syncblank: vsync_lines=%0d vblank_lines=%0d required %0d/%0d",
                     vs_lines, vb_lines, 2 * VS, 2 * (VT - VA));
        end
        $display("test_mode_switch: dbl frame %0d clocks, vsync %0d lines, vblank %0d lines", total, vs_lines, vb_lines);
    endtask

    task automatic test_reset_mid();
        int gap;
        int n = 0;
        while (!(hcount == 4'd5 && vcount == 4'd3) && n < 800) begin
            next_pulse(gap);
            n++;
        end
        checks++;
        if (hcount !== 4'd5 || vcount !== 4'd3) begin
            errors++;
            $display("FAIL mid_reach: h/v=%0d/%0d required 5/3", hcount, vcount);
        end
        #2;
        reset_n = 1'b0;
        scandouble = 1'b0;
        #1;
        check_reset_values("mid_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("mid_held");
        release_and_first_pulse("mid_release");
        next_pulse(gap);
        checks++;
        if (gap !== CED || mode_dbl !== 1'b0) begin
            errors++;
            $display("FAIL mid_mode: gap=%0d mode=%b required %0d/0", gap, mode_dbl, CED);
        end
    endtask

    initial begin
        test_reset();
        test_first_pulse();
        test_line_sweep();
        test_frame_sweep();
        test_mode_switch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the demo cores. It is the successor to the fixed 320x240 timing inside the current demo video block.
- Produces pixel clock-enable, sync, blank, and position counters from the system clock.
- Supports a runtime scandouble mode: doubled pixel rate with line repetition. Mode changes take effect only at frame boundaries.
- Sits between the emu top and any pixel source; outputs drive CE_PIXEL and VGA_HS/VS/DE directly.

Parameters:
H_ACTIVE, 320, visible pixels per line
H_FP, 8, horizontal front porch (pixels)
H_SYNC, 32, horizontal sync width (pixels)
H_BP, 40, horizontal back porch (pixels)
V_ACTIVE, 240, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 15, vertical back porch (lines)
CE_DIV, 4, clocks per pixel in normal mode; even, >=2
HS_POL, 0, active level of HSync
VS_POL, 0, active level of VSync

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
scandouble  in  1  requested mode: 1 = doubled rate and line repeat
ce_pix  out  1  one-clk pixel enable
HBlank  out  1  high when hcount >= H_ACTIVE
VBlank  out  1  high when vcount >= V_ACTIVE
HSync  out  1  HS_POL while hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
VSync  out  1  VS_POL while vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
hcount  out  HW  pixel position, HW = $clog2(H_TOTAL)
vcount  out  VW  source line, VW = $clog2(V_TOTAL)
line_rep  out  1  repetition index of the current line (always 0 when not scandoubled)
line_start  out  1  high for the ce_pix pulse where hcount = 0
frame_start  out  1  high for the ce_pix pulse where hcount = 0, vcount = 0, line_rep = 0
mode_dbl  out  1  mode currently in effect

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Region order per axis is active, then front porch, then sync, then back porch.
- Reset (reset_n low, asynchronous):
  - cdiv = 0, ce_pix = 0.
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1, line_rep = 1.
  - mode_dbl = 0.
  - HBlank = 1, VBlank = 1.
  - HSync = !HS_POL, VSync = !VS_POL.
  - line_start = 0, frame_start = 0.
- Divider:
  - div = mode_dbl ? CE_DIV/2 : CE_DIV.
  - cdiv counts 0..div-1 and wraps.
  - ce_pix is registered and goes high in the cycle after cdiv = div-1. The first ce_pix arrives on the div-th clock after reset release.
- Advance: on each edge that sets ce_pix, the position advances and all timing outputs are registered from the new position, so outputs are valid throughout the ce_pix pulse.
  - hcount increments and wraps at H_TOTAL-1.
  - On hcount wrap in normal mode, vcount increments.
  - On hcount wrap in scandouble mode, line_rep toggles; vcount increments only when line_rep goes 1 -> 0.
  - vcount wraps at V_TOTAL-1.
  - In normal mode line_rep is held at 1 internally so that wrap logic is uniform; the output is forced to 0.
- The first advance after reset yields (0,0,0) with line_start = 1 and frame_start = 1.
- Mode latch:
  - scandouble is sampled into mode_dbl only on the advance that produces frame_start, which is the wrap from the last pixel of the last line.
  - The divider length changes from the next cdiv cycle onward.
  - Toggles of scandouble mid-frame are ignored until the frame wrap.
- Sync/blank in scandouble mode are in source-line units: VSync spans 2*V_SYNC output lines and VBlank spans 2*(V_TOTAL-V_ACTIVE) output lines.
- Frame period in clocks is identical in both modes: CE_DIV*H_TOTAL*V_TOTAL.
- Reset mid-frame returns every output immediately to its reset value; there is no partial-line output.

Decomposition:
- Package video_timing_pkg:
  - localparam-friendly functions for totals and counter widths.
  - typedef struct video_timing_t {h_active, h_fp, h_sync, h_bp, v_*}.
  - Named presets TIMING_320x240_NTSC and TIMING_640x480_VGA.
- One sub-module, video_ce_div: the divider with runtime div select and pulse output.

Test Plan:
1. Defaults, scandouble = 0, release reset → first ce_pix on clock 4, then every 4 clocks. First pulse has hcount = 0, vcount = 0, frame_start = 1, HBlank = 0.
2. Normal-mode line sweep:
   - HBlank rises at hcount = 320.
   - HSync goes low for hcount 328..359 (32 pulses).
   - Line period is 1600 clocks.
   - line_start repeats every 400 ce_pix pulses.
3. Frame sweep:
   - VBlank covers vcount 240..261.
   - VSync is low for vcount 243..246.
   - frame_start recurs every 419200 clocks.
4. Set scandouble = 1 mid-frame → mode_dbl stays 0 until the frame wrap. After the wrap, ce_pix comes every 2 clocks, each vcount appears twice (line_rep 0 then 1), and the frame is still 419200 clocks.
5. Scandouble frame: VSync is asserted for 8 output lines (vcount 243..246, both reps) and VBlank for 44 output lines.
6. Assert reset_n = 0 at hcount = 150, vcount = 100 → outputs reach reset values asynchronously. After release, the first ce_pix again arrives on clock 4 with frame_start = 1.
